perf_sample_sched: RTL
======================

// Module: perf_sample_sched
// PURPOSE
//  Arbiter and scheduler for the perf_counters CSR-style port (addr/we/wdata/rdata, combinational read).
//  Shares that port between the CSR file (priority requester) and an autonomous sampler.
//  Every SAMPLE period the sampler reads the masked mhpmcounterN registers and pushes them into an output FIFO for a trace/debug sink.
//  Sits between csr_regfile and perf_counters in the CVA6 core.
// PARAMETERS
//  MHPMCounterNum  6   number of generic counters; counter k is at CSR_MHPM_COUNTER_3+k
//  FIFO_DEPTH      4   sample FIFO entries; must be a power of 2 and >=2
//  STARVE_LIMIT    8   consecutive cycles the sampler is denied before it is forced one grant
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      asynchronous reset, active-high
//  csr_req_i      in   1      CSR file access request to the perf block
//  csr_we_i       in   1      CSR write
//  csr_addr_i     in   12     CSR address
//  csr_wdata_i    in   XLEN   CSR write data
//  csr_gnt_o      out  1      CSR access performed this cycle
//  csr_rdata_o    out  XLEN   read data; valid when csr_gnt_o
//  perf_addr_o    out  12     to perf_counters addr_i
//  perf_we_o      out  1      to perf_counters we_i
//  perf_wdata_o   out  XLEN   to perf_counters data_i
//  perf_rdata_i   in   XLEN   from perf_counters data_o (same cycle)
//  sample_en_i    in   1      sampler enable
//  sample_period_i in  32     cycles between sample ticks; 0 = disabled
//  sample_mask_i  in   MHPMCounterNum  counters included in a sweep
//  smp_valid_o    out  1      FIFO head valid
//  smp_ready_i    in   1      sink accepts head
//  smp_idx_o      out  5      counter index k of head
//  smp_data_o     out  XLEN   counter value of head
//  smp_last_o     out  1      head is the last entry of its sweep
//  smp_ts_o       out  64     tick timestamp of head (see CONFIGURATION)
//  smp_drop_o     out  16     saturating count of ticks dropped
// BEHAVIOUR
//  - Reset: FSM=IDLE; period counter=0; FIFO empty; drop=0; all outputs 0; no perf port access issued.
//  - Tick: period counter runs while sample_en_i && period!=0; tick when count==period-1, then count<=0.
//    The counter is cleared while disabled. Period 1 gives a tick every cycle.
//  - Tick handling:
//    - IDLE: latch mask into mask_q and enter SCAN; a mask of 0 ignores the tick (no drop).
//    - SCAN: the tick is dropped and smp_drop_o increments, saturating at 16'hFFFF.
//  - SCAN:
//    - idx_q = lowest set bit of mask_q.
//    - Sampler wants the port when FIFO not full (pop this cycle does not count as space).
//    - Sampler slot: perf_addr_o=CSR_MHPM_COUNTER_3+idx_q, we=0; push {idx_q, perf_rdata_i, last}; clear bit idx_q.
//    - Pushing the last set bit sets last=1 and returns FSM to IDLE the next cycle.
//  - Arbitration, per cycle:
//    - CSR wins unless starve_q==STARVE_LIMIT and the sampler wants the port; then the sampler wins.
//    - starve_q increments when the sampler wants the port and loses; it resets on a sampler grant or when the sampler does not want the port.
//    - csr_gnt_o = csr_req_i && !sampler_win, combinational; a single-cycle access.
//    - On a CSR grant, perf_* mirror csr_* and csr_rdata_o = perf_rdata_i; otherwise csr_rdata_o=0.
//    - When idle, perf_addr_o=0 and perf_we_o=0.
//  - FIFO full: the sampler holds idx_q and retries; no loss within a sweep.
//  - FIFO empty: smp_valid_o=0. Push and pop in the same cycle are both allowed.
//  - Output: head held stable while smp_valid_o && !smp_ready_i.
//  - Sweeps are not atomic: counters keep counting between reads. CSR writes during SCAN are legal and visible to later reads.
//  - sample_en_i falling mid-SCAN completes the current sweep; FIFO contents are kept.
//  - Asynchronous reset mid-SCAN aborts the sweep and empties the FIFO.
// CONFIGURATION
//  PERF_SAMPLE_TIMESTAMP_EN:
//  - Defined: a 64-bit free-running cycle counter (reset 0, wraps) is captured at each accepted tick; every entry of that sweep carries it on smp_ts_o.
//  - Undefined: the counter and timestamp storage are not built and smp_ts_o is tied to 0.
// TESTING
//  - Reset: rst_i=1 mid-SCAN with 2 entries queued -> next cycle smp_valid_o=0, smp_drop_o=0, perf_we_o=0.
//  - Sweep:
//    - Stimulus: period=10, mask=6'b000101, ready=1, no CSR traffic.
//    - Response: reads at CSR_MHPM_COUNTER_3 then +2; entries idx 0 then idx 2 (last=1), repeating every 10 cycles.
//  - CSR priority:
//    - Stimulus: csr_req_i held high through a sweep, STARVE_LIMIT=8.
//    - Response: sampler granted exactly every 9th cycle with csr_gnt_o=0 that cycle; CSR rdata equals perf_rdata_i whenever granted.
//  - Backpressure/drop:
//    - Stimulus: FIFO_DEPTH=4, mask=6'h3F, ready=0, period=3.
//    - Response: 4 entries then stall; smp_drop_o increments every 3 cycles; releasing ready delivers the remaining idx 4,5 with no gaps in idx.
//  - Mask=0 or period=0: no perf reads, no FIFO pushes, smp_drop_o stays 0 over 100 cycles.
//  - With PERF_SAMPLE_TIMESTAMP_EN: both entries of one sweep carry an identical smp_ts_o; consecutive sweeps at period=10 differ by 10.

Source files
------------

// File: rtl/perf_sample_sched.sv
// Shares the perf_counters CSR port between the CSR file and a periodic counter sampler.
// Optional PERF_SAMPLE_TIMESTAMP_EN stamps every sweep with a 64-bit cycle count.
module perf_sample_sched #(
    parameter int unsigned MHPMCounterNum     = 6,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter int unsigned STARVE_LIMIT       = 8,
    parameter int unsigned XLEN               = 64,
    parameter logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      csr_req_i,
    input  logic                      csr_we_i,
    input  logic [11:0]               csr_addr_i,
    input  logic [XLEN-1:0]           csr_wdata_i,
    output logic                      csr_gnt_o,
    output logic [XLEN-1:0]           csr_rdata_o,
    output logic [11:0]               perf_addr_o,
    output logic                      perf_we_o,
    output logic [XLEN-1:0]           perf_wdata_o,
    input  logic [XLEN-1:0]           perf_rdata_i,
    input  logic                      sample_en_i,
    input  logic [31:0]               sample_period_i,
    input  logic [MHPMCounterNum-1:0] sample_mask_i,
    output logic                      smp_valid_o,
    input  logic                      smp_ready_i,
    output logic [4:0]                smp_idx_o,
    output logic [XLEN-1:0]           smp_data_o,
    output logic                      smp_last_o,
    output logic [63:0]               smp_ts_o,
    output logic [15:0]               smp_drop_o
);

    localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned STW  = $clog2(STARVE_LIMIT + 2);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [MHPMCounterNum-1:0] mask_q, mask_d;
    logic [15:0]               drop_q, drop_d;
    logic [STW-1:0]            starve_q, starve_d;
    logic [PTRW:0]             wr_q, rd_q;

    logic                      tick;
    logic [4:0]                scan_idx;
    logic [MHPMCounterNum-1:0] mask_rest;
    logic                      last;
    logic                      full;
    logic                      empty;
    logic                      smp_want;
    logic                      smp_gnt;
    logic                      push;
    logic                      pop;
    logic [PTRW:0]             fill;
    logic [PTRW-1:0]           wa;
    logic [PTRW-1:0]           ra;

    logic [4:0]                idx_mem  [FIFO_DEPTH];
    logic [XLEN-1:0]           data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     last_mem;

    // Tick generator: cleared whenever sampling is disabled.
    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (sample_en_i && (sample_period_i != 32'd0)) begin
            if (cnt_q == sample_period_i - 32'd1) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        scan_idx = '0;
        for (int i = int'(MHPMCounterNum) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                scan_idx = 5'(i);
            end
        end
    end

    assign mask_rest = mask_q & ~(MHPMCounterNum'(1) << scan_idx);
    assign last      = (mask_rest == '0);

    assign fill  = wr_q - rd_q;
    assign full  = (fill == (PTRW+1)'(FIFO_DEPTH));
    assign empty = (wr_q == rd_q);
    assign wa    = wr_q[PTRW-1:0];
    assign ra    = rd_q[PTRW-1:0];

    // A same-cycle pop does not free a slot for the sampler.
    assign smp_want = (state_q == SCAN) && !full;
    assign smp_gnt  = smp_want &&
                      (!csr_req_i || (starve_q == STW'(STARVE_LIMIT)));
    assign push     = smp_gnt;
    assign pop      = !empty && smp_ready_i;
    assign starve_d = (smp_want && !smp_gnt) ? starve_q + STW'(1) : '0;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (tick && (sample_mask_i != '0)) begin
                    mask_d  = sample_mask_i;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (tick && (drop_q != 16'hFFFF)) begin
                    drop_d = drop_q + 16'd1;
                end
                if (smp_gnt) begin
                    mask_d = mask_rest;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        csr_gnt_o    = csr_req_i && !smp_gnt;
        csr_rdata_o  = '0;
        perf_addr_o  = '0;
        perf_we_o    = 1'b0;
        perf_wdata_o = '0;
        if (smp_gnt) begin
            perf_addr_o = CSR_MHPM_COUNTER_3 + 12'(scan_idx);
        end else if (csr_gnt_o) begin
            perf_addr_o  = csr_addr_i;
            perf_we_o    = csr_we_i;
            perf_wdata_o = csr_wdata_i;
            csr_rdata_o  = perf_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            drop_q   <= '0;
            starve_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
            if (push) begin
                wr_q <= wr_q + (PTRW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (PTRW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem[wa]  <= scan_idx;
            data_mem[wa] <= perf_rdata_i;
            last_mem[wa] <= last;
        end
    end

    assign smp_valid_o = !empty;
    assign smp_idx_o   = empty ? '0 : idx_mem[ra];
    assign smp_data_o  = empty ? '0 : data_mem[ra];
    assign smp_last_o  = !empty && last_mem[ra];
    assign smp_drop_o  = drop_q;

`ifdef PERF_SAMPLE_TIMESTAMP_EN
    logic [63:0] cyc_q;
    logic [63:0] ts_q;
    logic [63:0] ts_mem [FIFO_DEPTH];
    logic        accept;

    assign accept = (state_q == IDLE) && tick && (sample_mask_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (accept) begin
                ts_q <= cyc_q;
            end
        end
    end

    // The stamp is registered one cycle before the sweep's first push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ts_mem[wa] <= ts_q;
        end
    end

    assign smp_ts_o = empty ? '0 : ts_mem[ra];
`else
    assign smp_ts_o = '0;
`endif

endmodule
